// File: rtl/ex_muldiv_unit.sv
// Iterative MIPS multiply/divide unit: one shift-add or restoring shift-subtract
// step per cycle, results committed to the architectural HI/LO registers.
module ex_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int SIGNED_EN = 1,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_r, state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] acc_r, q_r, m_r, hi_r, lo_r;
  logic             is_div_r, neg_lo_r, neg_hi_r;
  logic             busy_r, done_r, dbz_r;

  logic             signed_op_s, a_neg_s, b_neg_s;
  logic             launch_s, dbz_launch_s, last_step_s;
  logic [WIDTH-1:0] a_mag_s, b_mag_s;
  logic [WIDTH:0]   mul_sum_s, div_shift_s;
  logic [WIDTH-1:0] acc_step_s, q_step_s, res_hi_s, res_lo_s;
  logic [2*WIDTH-1:0] prod_s, prod_fix_s;

  // Operand decode: magnitudes and launch qualification.
  always_comb begin
    signed_op_s  = (SIGNED_EN != 0) && !op[0];
    a_neg_s      = signed_op_s && op_a[WIDTH-1];
    b_neg_s      = signed_op_s && op_b[WIDTH-1];
    a_mag_s      = a_neg_s ? (~op_a + 1'b1) : op_a;
    b_mag_s      = b_neg_s ? (~op_b + 1'b1) : op_b;
    launch_s     = start && (state_r != ST_CALC) && !flush;
    dbz_launch_s = launch_s && op[1] && (op_b == {WIDTH{1'b0}});
    last_step_s  = (cnt_r == CNT_W'(1));
  end

  // One iteration step plus the sign-corrected result of the final step.
  always_comb begin
    mul_sum_s   = {1'b0, acc_r} + (q_r[0] ? {1'b0, m_r} : {(WIDTH+1){1'b0}});
    div_shift_s = {acc_r, q_r[WIDTH-1]};
    acc_step_s  = {WIDTH{1'b0}};
    q_step_s    = {WIDTH{1'b0}};
    res_hi_s    = {WIDTH{1'b0}};
    res_lo_s    = {WIDTH{1'b0}};
    if (is_div_r) begin
      // Partial remainder is < 2*divisor, so the low WIDTH bits of the difference are exact.
      if (div_shift_s >= {1'b0, m_r}) begin
        acc_step_s = div_shift_s[WIDTH-1:0] - m_r;
        q_step_s   = {q_r[WIDTH-2:0], 1'b1};
      end else begin
        acc_step_s = div_shift_s[WIDTH-1:0];
        q_step_s   = {q_r[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_step_s = mul_sum_s[WIDTH:1];
      q_step_s   = {mul_sum_s[0], q_r[WIDTH-1:1]};
    end
    prod_s     = {acc_step_s, q_step_s};
    prod_fix_s = neg_lo_r ? (~prod_s + 1'b1) : prod_s;
    if (is_div_r) begin
      res_lo_s = neg_lo_r ? (~q_step_s + 1'b1) : q_step_s;
      res_hi_s = neg_hi_r ? (~acc_step_s + 1'b1) : acc_step_s;
    end else begin
      res_hi_s = prod_fix_s[2*WIDTH-1:WIDTH];
      res_lo_s = prod_fix_s[WIDTH-1:0];
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (launch_s) begin
          state_nxt_s = dbz_launch_s ? ST_DONE : ST_CALC;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (flush) begin
          state_nxt_s = ST_IDLE;
        end else if (last_step_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_CALC;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      dbz_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s == ST_CALC);
      done_r  <= (state_nxt_s == ST_DONE);
      dbz_r   <= dbz_launch_s;
    end
  end

  // Datapath: operand capture, iteration, HI/LO commit and MTHI/MTLO writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r    <= {CNT_W{1'b0}};
      acc_r    <= {WIDTH{1'b0}};
      q_r      <= {WIDTH{1'b0}};
      m_r      <= {WIDTH{1'b0}};
      hi_r     <= {WIDTH{1'b0}};
      lo_r     <= {WIDTH{1'b0}};
      is_div_r <= 1'b0;
      neg_lo_r <= 1'b0;
      neg_hi_r <= 1'b0;
    end else if (launch_s) begin
      acc_r    <= {WIDTH{1'b0}};
      is_div_r <= op[1];
      neg_lo_r <= a_neg_s ^ b_neg_s;
      cnt_r    <= dbz_launch_s ? {CNT_W{1'b0}} : CNT_W'(WIDTH);
      if (op[1]) begin
        q_r      <= a_mag_s;
        m_r      <= b_mag_s;
        neg_hi_r <= a_neg_s;
      end else begin
        q_r      <= b_mag_s;
        m_r      <= a_mag_s;
        neg_hi_r <= a_neg_s ^ b_neg_s;
      end
      if (dbz_launch_s) begin
        hi_r <= op_a;
        lo_r <= {WIDTH{1'b1}};
      end
    end else if (state_r == ST_CALC) begin
      if (flush) begin
        cnt_r <= {CNT_W{1'b0}};
      end else begin
        acc_r <= acc_step_s;
        q_r   <= q_step_s;
        cnt_r <= cnt_r - CNT_W'(1);
        if (last_step_s) begin
          hi_r <= res_hi_s;
          lo_r <= res_lo_s;
        end
      end
    end else if (!start) begin
      if (hi_we) hi_r <= wdata;
      if (lo_we) lo_r <= wdata;
    end
  end

  assign busy        = busy_r;
  assign done        = done_r;
  assign div_by_zero = dbz_r;
  assign hi          = hi_r;
  assign lo          = lo_r;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed vector table, hand-written
// multi-cycle sequences and randomized operations against an arithmetic model.
module tb_ex_muldiv_unit;
  localparam int W = 32;
  localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;

  logic          clk = 1'b0;
  logic          rst_n, start, flush, hi_we, lo_we;
  logic [1:0]    op;
  logic [W-1:0]  op_a, op_b, wdata;
  logic          busy, done, div_by_zero;
  logic [W-1:0]  hi, lo;

  int n_checks = 0;
  int n_fail = 0;
  int dbz_stray = 0;

  ex_muldiv_unit #(.WIDTH(W), .SIGNED_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .op_a(op_a), .op_b(op_b),
    .flush(flush), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (div_by_zero && !done) dbz_stray++;
  end

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_hi;
    logic [W-1:0] exp_lo;
    logic         exp_dbz;
  } vec_t;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Results computed directly from the MIPS arithmetic definitions.
  function automatic void ref_model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] rh, output logic [W-1:0] rl, output logic rz);
    longint sa, sb, p;
    logic [63:0] up;
    rz = 1'b0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (!o[1]) begin
      if (!o[0]) begin
        p = sa * sb;
        {rh, rl} = p;
      end else begin
        up = {32'h0, a} * {32'h0, b};
        {rh, rl} = up;
      end
    end else if (b == 32'h0) begin
      rz = 1'b1;
      rh = a;
      rl = 32'hFFFF_FFFF;
    end else if (!o[0]) begin
      rl = 32'(sa / sb);
      rh = 32'(sa % sb);
    end else begin
      rl = a / b;
      rh = a % b;
    end
  endfunction

  task automatic drive_start(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1;
    op    = o;
    op_a  = a;
    op_b  = b;
  endtask

  // Step through cycles until done (bounded); cycle 1 is the negedge after the start cycle.
  task automatic wait_done(output int cyc, output int busy_cyc);
    cyc = 0;
    busy_cyc = 0;
    while (cyc < 100) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (done) break;
      if (busy) busy_cyc++;
    end
  endtask

  task automatic run_check(input string name, input logic [1:0] o, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [W-1:0] eh, input logic [W-1:0] el,
                           input logic ez);
    int cyc, bc;
    @(negedge clk);
    drive_start(o, a, b);
    wait_done(cyc, bc);
    chk({name, " latency"}, 32'(cyc), ez ? 32'd1 : 32'(W + 1));
    chk({name, " busy_cycles"}, 32'(bc), ez ? 32'd0 : 32'(W));
    chk({name, " busy_at_done"}, {31'd0, busy}, 32'd0);
    chk({name, " hi"}, hi, eh);
    chk({name, " lo"}, lo, el);
    chk({name, " div_by_zero"}, {31'd0, div_by_zero}, {31'd0, ez});
    @(negedge clk);
    chk({name, " done_pulse"}, {31'd0, done}, 32'd0);
  endtask

  task automatic write_hilo(input logic h, input logic l, input logic [W-1:0] d);
    @(negedge clk);
    hi_we = h;
    lo_we = l;
    wdata = d;
    @(negedge clk);
    hi_we = 1'b0;
    lo_we = 1'b0;
  endtask

  vec_t vecs[10];

  initial begin
    int cyc, bc, nd, nb;
    logic [W-1:0] rh, rl, ra, rb;
    logic rz;
    logic [1:0] ro;

    vecs[0] = '{OP_MULT,  32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0};
    vecs[1] = '{OP_DIVU,  32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E, 1'b0};
    vecs[2] = '{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[3] = '{OP_DIV,   32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF, 1'b1};
    vecs[4] = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
    vecs[5] = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    vecs[6] = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
    vecs[7] = '{OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
    vecs[8] = '{OP_DIVU,  32'h0000_0007, 32'hFFFF_FFFF, 32'h0000_0007, 32'h0000_0000, 1'b0};
    vecs[9] = '{OP_DIVU,  32'hABCD_0000, 32'h0000_0000, 32'hABCD_0000, 32'hFFFF_FFFF, 1'b1};

    rst_n = 1'b0; start = 1'b0; flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = 2'b00; op_a = 32'h0; op_b = 32'h0; wdata = 32'h0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset dbz", {31'd0, div_by_zero}, 32'd0);
    chk("reset hi", hi, 32'h0);
    chk("reset lo", lo, 32'h0);

    for (int i = 0; i < 10; i++) begin
      run_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].exp_dbz);
    end

    // Simultaneous MTHI/MTLO, then separate preloads.
    write_hilo(1'b1, 1'b1, 32'h0000_0033);
    chk("mthi_mtlo hi", hi, 32'h0000_0033);
    chk("mthi_mtlo lo", lo, 32'h0000_0033);
    write_hilo(1'b1, 1'b0, 32'h0000_0011);
    write_hilo(1'b0, 1'b1, 32'h0000_0022);
    chk("preload hi", hi, 32'h0000_0011);
    chk("preload lo", lo, 32'h0000_0022);

    // Flush sequence: start in cycle 3 ignored, MTHI in cycle 4 ignored, flush in cycle 5.
    @(negedge clk);
    drive_start(OP_MULTU, 32'd3, 32'd4);
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); drive_start(OP_MULTU, 32'd9, 32'd9);
    @(negedge clk); start = 1'b0; hi_we = 1'b1; wdata = 32'h0000_DEAD;
    @(negedge clk); hi_we = 1'b0; flush = 1'b1;
    chk("flush busy_c5", {31'd0, busy}, 32'd1);
    chk("mthi_busy hi", hi, 32'h0000_0011);
    @(negedge clk); flush = 1'b0;
    chk("flush busy_c6", {31'd0, busy}, 32'd0);
    nd = 0; nb = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) nd++;
      if (busy) nb++;
      @(negedge clk);
    end
    chk("flush no_done", 32'(nd), 32'd0);
    chk("flush no_busy", 32'(nb), 32'd0);
    chk("flush hi", hi, 32'h0000_0011);
    chk("flush lo", lo, 32'h0000_0022);

    // Start in cycle 3 while busy must not recapture operands or restart.
    drive_start(OP_MULTU, 32'd3, 32'd4);
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); drive_start(OP_MULTU, 32'd5, 32'd5);
    wait_done(cyc, bc);
    chk("ignored_start latency", 32'(cyc + 3), 32'(W + 1));
    chk("ignored_start lo", lo, 32'd12);
    chk("ignored_start hi", hi, 32'd0);

    // Back-to-back: second start issued during DONE.
    @(negedge clk);
    @(negedge clk);
    drive_start(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(cyc, bc);
    chk("b2b first latency", 32'(cyc), 32'(W + 1));
    chk("b2b first lo", lo, 32'h8000_0000);
    chk("b2b first hi", hi, 32'h0);
    drive_start(OP_MULTU, 32'd6, 32'd7);
    wait_done(cyc, bc);
    chk("b2b second latency", 32'(cyc), 32'(W + 1));
    chk("b2b second busy_cycles", 32'(bc), 32'(W));
    chk("b2b second lo", lo, 32'd42);
    chk("b2b second hi", hi, 32'd0);

    // Asynchronous reset mid-CALC.
    write_hilo(1'b1, 1'b0, 32'h0000_0055);
    write_hilo(1'b0, 1'b1, 32'h0000_0066);
    @(negedge clk);
    drive_start(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("pre_reset busy", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset busy", {31'd0, busy}, 32'd0);
    chk("async_reset done", {31'd0, done}, 32'd0);
    chk("async_reset hi", hi, 32'h0);
    chk("async_reset lo", lo, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    nd = 0; nb = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) nd++;
      if (busy) nb++;
    end
    chk("post_reset no_done", 32'(nd), 32'd0);
    chk("post_reset no_busy", 32'(nb), 32'd0);

    // Randomized operations against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      case ($urandom_range(0, 9))
        0:       rb = 32'h0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = 32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      ref_model(ro, ra, rb, rh, rl, rz);
      run_check($sformatf("rand%0d op%0d %0h %0h", i, ro, ra, rb), ro, ra, rb, rh, rl, rz);
    end

    chk("dbz_without_done", 32'(dbz_stray), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
Iterative multiply/divide unit for the EX stage. It runs MIPS MULT/MULTU/DIV/DIVU over WIDTH cycles and holds results in architectural HI/LO registers. While an operation is in flight it raises busy, which the hazard logic uses to stall any MFHI/MFLO or new mul/div. It also accepts MTHI/MTLO writes when idle.

Parameters:
WIDTH, 32, operand and HI/LO width; must be at least 4.
SIGNED_EN, 1, when 0 the signed opcodes execute as their unsigned variants.
CNT_W, $clog2(WIDTH)+1, iteration counter width; derived, not overridden.

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  asynchronous, active-low reset
start  in  1  launch request, sampled when not busy
op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
op_a  in  WIDTH  rs operand (multiplicand / dividend), captured at start
op_b  in  WIDTH  rt operand (multiplier / divisor), captured at start
flush  in  1  abort the in-flight operation (EX flush)
hi_we  in  1  MTHI write enable
lo_we  in  1  MTLO write enable
wdata  in  WIDTH  MTHI/MTLO data
busy  out  1  operation in flight
done  out  1  single-cycle completion pulse
div_by_zero  out  1  qualifies done; divide with op_b==0
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; busy=0, done=0, div_by_zero=0, hi=0, lo=0, counter=0. Reset during CALC abandons the operation with no done pulse.
- FSM states are IDLE, CALC and DONE.
- IDLE or DONE with start=1:
  - Capture operand magnitudes and the result sign, then go to CALC with counter=WIDTH.
  - Exception: DIV/DIVU with op_b==0 goes straight to DONE.
  - DONE lasts one cycle and then returns to IDLE unless a new start is accepted, which allows back-to-back operations.
- Cycle timing, with start high in cycle 0:
  - Cycles 1..WIDTH: busy=1. One shift-add step (multiply) or one restoring shift-subtract step (divide) per cycle; counter decrements.
  - The edge ending cycle WIDTH applies the sign correction and writes hi/lo.
  - Cycle WIDTH+1: state DONE, done=1, busy=0, and the new hi/lo are visible.
- Multiply: the 2*WIDTH-bit product goes to {hi,lo}. For signed ops, operands are converted to magnitudes and the product is negated when the operand signs differ.
- Divide:
  - lo = quotient, hi = remainder; quotient truncates toward zero.
  - The remainder takes the sign of the dividend.
  - Signed most-negative / -1 wraps: lo = most-negative, hi = 0.
- Divide by zero: no CALC phase. In cycle 1, done=1 and div_by_zero=1; lo = all ones and hi = op_a.
- div_by_zero is 0 whenever done is 0.
- start while busy=1 is ignored; operands are not recaptured.
- flush while busy=1: return to IDLE at the next edge. No done pulse; hi/lo keep their pre-operation values.
  - flush with start in the same cycle: flush wins and nothing is launched.
  - flush in DONE has no effect, since results are already committed.
- hi_we/lo_we are honoured only when busy=0 and start=0. They take effect at the edge, and both may be written in the same cycle. They are ignored while busy, and when start is asserted in the same cycle start wins.
- Arithmetic is modulo 2^WIDTH per register; no overflow flag is produced.
- With SIGNED_EN=0, op 00 behaves as 01 and op 10 behaves as 11.

Test Plan:
- WIDTH=32, MULT op_a=0xFFFFFFFD (-3), op_b=5 -> busy high in cycles 1..32; in cycle 33 done=1, hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- DIVU op_a=100, op_b=7 -> done in cycle 33 with lo=0x0000000E, hi=0x00000002. Then DIV op_a=0xFFFFFFF9 (-7), op_b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV op_a=5, op_b=0 -> cycle 1 has done=1 and div_by_zero=1 with lo=0xFFFFFFFF, hi=0x00000005; busy never rises.
- hi/lo preloaded to 0x11/0x22, then MULTU launched and flush asserted in cycle 5 -> busy=0 from cycle 6, no done pulse, hi=0x11, lo=0x22. A start issued in cycle 3 must be ignored.
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0. A back-to-back start during DONE launches immediately, and the second done arrives WIDTH+1 cycles later.
- rst_n pulsed low mid-CALC -> hi/lo/busy/done clear asynchronously with no done pulse. Also check that a hi_we write while busy is ignored and that simultaneous hi_we and lo_we while idle update both registers.
